// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch-side branch predictor:
// predictor mode selectors and counter init/max helpers.
package cpu_pkg;

    localparam int BP_STATIC  = 0;
    localparam int BP_BIMODAL = 1;
    localparam int BP_GSHARE  = 2;

    // Weakly not-taken start value for a w-bit counter.
    function automatic int ctr_init(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Strongly taken value for a w-bit counter.
    function automatic int ctr_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter next-state logic with set-to-max.
// Ports: cur_i current value, set_max_i force max, inc_i up(1)/down(0), nxt_o next value.
module sat_counter
    import cpu_pkg::*;
#(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] cur_i,
    input  logic             set_max_i,
    input  logic             inc_i,
    output logic [CTR_W-1:0] nxt_o
);

    localparam logic [CTR_W-1:0] MAX = CTR_W'(ctr_max(CTR_W));

    always_comb begin
        nxt_o = cur_i;
        if (set_max_i) begin
            nxt_o = MAX;
        end else if (inc_i) begin
            if (cur_i != MAX) nxt_o = cur_i + 1'b1;
        end else begin
            if (cur_i != '0) nxt_o = cur_i - 1'b1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: BTB + saturating counters, static/bimodal/gshare.
// Ports: lk_pc_i lookup -> pred_taken_o/pred_target_o; upd_* resolved outcome
// from ID -> mispredict_o (combinational), stat_mispred_o saturating count.
module branch_predictor
    import cpu_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 32,
    parameter int CTR_W   = 2,
    parameter int MODE    = 1,
    parameter int STAT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] lk_pc_i,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_is_jump_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_pred_taken_i,
    input  logic [ADDR_W-1:0] upd_pred_target_i,
    output logic              mispredict_o,
    output logic [STAT_W-1:0] stat_mispred_o
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CTR_W-1:0]  CTR_INIT = CTR_W'(ctr_init(CTR_W));
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic              valid_q [ENTRIES];
    logic [TAG_W-1:0]  tag_q   [ENTRIES];
    logic [ADDR_W-1:0] tgt_q   [ENTRIES];
    logic [CTR_W-1:0]  ctr_q   [ENTRIES];
    logic [IDX_W-1:0]  ghr_q, ghr_d;
    logic [STAT_W-1:0] stat_q;

    logic [IDX_W-1:0]  lk_bidx, lk_cidx, up_bidx, up_cidx;
    logic [TAG_W-1:0]  lk_tag, up_tag;
    logic              lk_hit, upd_en;
    logic [CTR_W-1:0]  ctr_d;
    logic              unused_pc_lsb;

    assign unused_pc_lsb = ^{lk_pc_i[1:0], upd_pc_i[1:0]};

    assign lk_bidx = lk_pc_i[IDX_W+1:2];
    assign lk_tag  = lk_pc_i[ADDR_W-1:IDX_W+2];
    assign up_bidx = upd_pc_i[IDX_W+1:2];
    assign up_tag  = upd_pc_i[ADDR_W-1:IDX_W+2];

    // Counter index hashes in history only for gshare; BTB stays on bidx.
    assign lk_cidx = (MODE == BP_GSHARE) ? (lk_bidx ^ ghr_q) : lk_bidx;
    assign up_cidx = (MODE == BP_GSHARE) ? (up_bidx ^ ghr_q) : up_bidx;

    assign lk_hit = valid_q[lk_bidx] && (tag_q[lk_bidx] == lk_tag);

    always_comb begin
        pred_taken_o  = 1'b0;
        pred_target_o = '0;
        if (rst_n_i && (MODE != BP_STATIC) && lk_hit) begin
            pred_taken_o  = ctr_q[lk_cidx][CTR_W-1];
            pred_target_o = tgt_q[lk_bidx];
        end
    end

    // Wrong direction, or right "taken" with the wrong target.
    assign mispredict_o = rst_n_i && upd_valid_i &&
        ((upd_taken_i != upd_pred_taken_i) ||
         (upd_taken_i && upd_pred_taken_i &&
          (upd_target_i != upd_pred_target_i)));

    assign upd_en = upd_valid_i && (MODE != BP_STATIC);

    sat_counter #(
        .CTR_W(CTR_W)
    ) u_ctr (
        .cur_i    (ctr_q[up_cidx]),
        .set_max_i(upd_is_jump_i),
        .inc_i    (upd_taken_i),
        .nxt_o    (ctr_d)
    );

    // Truncation keeps the low IDX_W bits, i.e. shift-in of the outcome.
    assign ghr_d = IDX_W'({ghr_q, upd_taken_i});

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_INIT;
            end
            ghr_q  <= '0;
            stat_q <= '0;
        end else begin
            if (upd_en) begin
                ctr_q[up_cidx] <= ctr_d;
                if (upd_taken_i) valid_q[up_bidx] <= 1'b1;
                if ((MODE == BP_GSHARE) && !upd_is_jump_i) ghr_q <= ghr_d;
            end
            if (mispredict_o && (stat_q != STAT_MAX)) begin
                stat_q <= stat_q + 1'b1;
            end
        end
    end

    // Tag/target payload needs no reset: it is qualified by valid_q.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && upd_en && upd_taken_i) begin
            tag_q[up_bidx] <= up_tag;
            tgt_q[up_bidx] <= upd_target_i;
        end
    end

    assign stat_mispred_o = stat_q;

endmodule
